xillybus_lite_regs: RTL and testbench



---
 rtl/xillybus_lite_regs.sv | 136 +++++++++++++
 tb/tb_xillybus_lite_regs.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/xillybus_lite_regs.sv
// Xillybus Lite register-file responder: ID/CTRL/STATUS/SCRATCH, a free-running timestamp
// and an event FIFO pushed by fabric and popped by host reads, with a level-threshold IRQ.
module xillybus_lite_regs #(
  parameter logic [31:0] ID_VALUE   = 32'h4D5A_0001,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 5
) (
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic        user_wren,
  input  logic [3:0]  user_wstrb,
  input  logic        user_rden,
  input  logic [31:0] user_addr,
  input  logic [31:0] user_wr_data,
  output logic [31:0] user_rd_data,
  output logic        user_irq,
  input  logic        evt_valid,
  input  logic [31:0] evt_data,
  output logic [31:0] ctrl_out
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [31:0]     ctrl_q, ctrl_d;
  logic [31:0]     scratch_q, scratch_d;
  logic [31:0]     ts_q, ts_d;
  logic [31:0]     rd_data_q, rd_data_d;
  logic            irq_q;
  logic            pend_q, pend_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] level_q, level_d;
  logic [31:0]     mem [FIFO_DEPTH];

  logic [31:0] sel;
  logic        empty, full, pop_req, do_pop, do_push, wr_status;
  logic [31:0] fifo_head, status, lvl_ext;

  logic unused_addr;
  assign unused_addr = ^{user_addr[31:ADDR_W], user_addr[1:0]};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = nw[8*i +: 8];
    end
    return res;
  endfunction

  always_comb begin
    sel       = 32'(user_addr[ADDR_W-1:2]);
    empty     = (level_q == '0);
    full      = (32'(level_q) == FIFO_DEPTH);
    pop_req   = user_rden && (sel == 32'd4);
    do_pop    = pop_req && !empty;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    do_push   = evt_valid && (!full || do_pop);
    level_d   = level_q + LvlW'(do_push) - LvlW'(do_pop);
    wr_status = user_wren && (sel == 32'd2) && user_wstrb[0];
    fifo_head = empty ? 32'h0 : mem[rd_ptr_q];
    lvl_ext   = 32'(level_q);

    status        = 32'h0;
    status[0]     = pend_q;
    status[1]     = empty;
    status[2]     = full;
    status[3]     = ovf_q;
    status[4]     = udf_q;
    status[23:16] = lvl_ext[7:0];

    ctrl_d    = (user_wren && sel == 32'd1) ? merge(ctrl_q, user_wr_data, user_wstrb) : ctrl_q;
    scratch_d = (user_wren && sel == 32'd3) ? merge(scratch_q, user_wr_data, user_wstrb)
                                            : scratch_q;
    ts_d      = (user_wren && sel == 32'd5 && user_wstrb != 4'h0) ? 32'h0 : ts_q + 32'd1;

    // Set conditions take priority over write-1-to-clear.
    pend_d = ((ctrl_q[15:8] != 8'h0) && (32'(level_d) >= 32'(ctrl_q[15:8])))
             || (pend_q && !(wr_status && user_wr_data[0]));
    ovf_d  = (evt_valid && full && !do_pop) || (ovf_q && !(wr_status && user_wr_data[3]));
    udf_d  = (pop_req && empty) || (udf_q && !(wr_status && user_wr_data[4]));

    rd_data_d = rd_data_q;
    if (user_rden) begin
      case (sel)
        32'd0:   rd_data_d = ID_VALUE;
        32'd1:   rd_data_d = ctrl_q;
        32'd2:   rd_data_d = status;
        32'd3:   rd_data_d = scratch_q;
        32'd4:   rd_data_d = fifo_head;
        32'd5:   rd_data_d = ts_q;
        default: rd_data_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      ctrl_q    <= 32'h0;
      scratch_q <= 32'h0;
      ts_q      <= 32'h0;
      rd_data_q <= 32'h0;
      irq_q     <= 1'b0;
      pend_q    <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      scratch_q <= scratch_d;
      ts_q      <= ts_d;
      rd_data_q <= rd_data_d;
      irq_q     <= pend_q & ctrl_q[0];
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      wr_ptr_q  <= wr_ptr_q + PtrW'(do_push);
      rd_ptr_q  <= rd_ptr_q + PtrW'(do_pop);
      level_q   <= level_d;
    end
  end

  always_ff @(posedge user_clk) begin
    if (!user_rst && do_push) mem[wr_ptr_q] <= evt_data;
  end

  assign user_rd_data = rd_data_q;
  assign user_irq     = irq_q;
  assign ctrl_out     = ctrl_q;

endmodule

// File: tb/tb_xillybus_lite_regs.sv
// Directed bench for xillybus_lite_regs: a vector table for register access plus hand
// sequences for FIFO, interrupt, timestamp and reset corner cases.
module tb_xillybus_lite_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        wren, rden, evt_valid;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata, rd_data, evt_data, ctrl_out;
  logic        irq;
  int          total = 0;
  int          bad = 0;

  localparam logic [31:0] IdVal = 32'h4D5A_0001;

  xillybus_lite_regs dut (
    .user_clk    (clk),
    .user_rst    (rst),
    .user_wren   (wren),
    .user_wstrb  (wstrb),
    .user_rden   (rden),
    .user_addr   (addr),
    .user_wr_data(wdata),
    .user_rd_data(rd_data),
    .user_irq    (irq),
    .evt_valid   (evt_valid),
    .evt_data    (evt_data),
    .ctrl_out    (ctrl_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp;
    logic [31:0] exp_ctrl;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All tasks start and end at a negedge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wren = 1'b1; addr = a; wdata = d; wstrb = s;
    @(negedge clk);
    wren = 1'b0; wstrb = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    rden = 1'b1; addr = a;
    @(negedge clk);
    rden = 1'b0;
    d = rd_data;
  endtask

  task automatic push(input logic [31:0] d);
    evt_valid = 1'b1; evt_data = d;
    @(negedge clk);
    evt_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    rst = 1'b1; wren = 1'b0; rden = 1'b0; evt_valid = 1'b0;
    wstrb = 4'h0; addr = 32'h0; wdata = 32'h0; evt_data = 32'h0;

    vecs[0]  = '{1'b1, 32'h00, 32'h0,         4'h0, IdVal,         32'h0};
    vecs[1]  = '{1'b1, 32'h04, 32'h0,         4'h0, 32'h0,         32'h0};
    vecs[2]  = '{1'b1, 32'h08, 32'h0,         4'h0, 32'h2,         32'h0};
    vecs[3]  = '{1'b1, 32'h20, 32'h0,         4'h0, IdVal,         32'h0};
    vecs[4]  = '{1'b0, 32'h0C, 32'hAABBCCDD,  4'hF, 32'h0,         32'h0};
    vecs[5]  = '{1'b0, 32'h0C, 32'h11223344,  4'h5, 32'h0,         32'h0};
    vecs[6]  = '{1'b1, 32'h0C, 32'h0,         4'h0, 32'hAA22CC44,  32'h0};
    vecs[7]  = '{1'b1, 32'h2C, 32'h0,         4'h0, 32'hAA22CC44,  32'h0};
    vecs[8]  = '{1'b0, 32'h18, 32'hFFFFFFFF,  4'hF, 32'h0,         32'h0};
    vecs[9]  = '{1'b1, 32'h18, 32'h0,         4'h0, 32'h0,         32'h0};
    vecs[10] = '{1'b0, 32'h04, 32'h12345678,  4'h3, 32'h0,         32'h5678};
    vecs[11] = '{1'b1, 32'h04, 32'h0,         4'h0, 32'h5678,      32'h5678};
    vecs[12] = '{1'b0, 32'h00, 32'hFFFFFFFF,  4'hF, 32'h0,         32'h5678};
    vecs[13] = '{1'b1, 32'h00, 32'h0,         4'h0, IdVal,         32'h5678};
    vecs[14] = '{1'b0, 32'h08, 32'hFFFFFFFF,  4'hF, 32'h0,         32'h5678};
    vecs[15] = '{1'b1, 32'h08, 32'h0,         4'h0, 32'h2,         32'h5678};
    vecs[16] = '{1'b0, 32'h04, 32'h0,         4'hF, 32'h0,         32'h0};
    vecs[17] = '{1'b1, 32'h04, 32'h0,         4'h0, 32'h0,         32'h0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset rd_data", rd_data, 32'h0);
    check("reset irq", {31'h0, irq}, 32'h0);
    check("reset ctrl_out", ctrl_out, 32'h0);
    rst = 1'b0;
    rd(32'h14, r);
    check("reset timestamp", r, 32'h0);

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].is_rd) begin
        rd(vecs[i].a, r);
        check($sformatf("vec%0d rd", i), r, vecs[i].exp);
      end else begin
        wr(vecs[i].a, vecs[i].d, vecs[i].s);
      end
      check($sformatf("vec%0d ctrl_out", i), ctrl_out, vecs[i].exp_ctrl);
    end

    // Read data holds until the next read strobe
    repeat (3) @(negedge clk);
    check("rd hold", rd_data, 32'h0);

    // Simultaneous read and write returns the pre-write value
    wren = 1'b1; rden = 1'b1; addr = 32'h0C; wdata = 32'h0BADF00D; wstrb = 4'hF;
    @(negedge clk);
    wren = 1'b0; rden = 1'b0; wstrb = 4'h0;
    check("rdwr old", rd_data, 32'hAA22CC44);
    rd(32'h0C, r);
    check("rdwr new", r, 32'h0BADF00D);

    // Basic FIFO and underflow
    for (int i = 0; i < 3; i++) push(32'h100 + i);
    rd(32'h08, r);
    check("fifo3 status", r, 32'h0003_0000);
    for (int i = 0; i < 3; i++) begin
      rd(32'h10, r);
      check($sformatf("fifo3 pop%0d", i), r, 32'h100 + i);
    end
    rd(32'h10, r);
    check("underflow data", r, 32'h0);
    rd(32'h08, r);
    check("underflow status", r, 32'h12);
    wr(32'h08, 32'h10, 4'h1);
    rd(32'h08, r);
    check("underflow clr", r, 32'h2);

    // Overflow, then push+pop on a full FIFO
    for (int i = 0; i < 17; i++) push(32'h200 + i);
    rd(32'h08, r);
    check("overflow status", r, 32'h0010_000C);
    evt_valid = 1'b1; evt_data = 32'h300; rden = 1'b1; addr = 32'h10;
    @(negedge clk);
    evt_valid = 1'b0; rden = 1'b0;
    check("full pushpop data", rd_data, 32'h200);
    rd(32'h08, r);
    check("full pushpop status", r, 32'h0010_000C);
    for (int i = 1; i < 16; i++) begin
      rd(32'h10, r);
      check($sformatf("drain%0d", i), r, 32'h200 + i);
    end
    rd(32'h10, r);
    check("drain last", r, 32'h300);
    rd(32'h08, r);
    check("drained status", r, 32'h0A);
    wr(32'h08, 32'h08, 4'h1);
    rd(32'h08, r);
    check("overflow clr", r, 32'h2);

    // Threshold interrupt
    wr(32'h04, 32'h0000_0401, 4'hF);
    for (int i = 0; i < 4; i++) push(32'hA0 + i);
    @(negedge clk);
    check("irq set", {31'h0, irq}, 32'h1);
    wr(32'h08, 32'h1, 4'h1);
    @(negedge clk);
    check("irq held at thresh", {31'h0, irq}, 32'h1);
    rd(32'h08, r);
    check("irq status", r, 32'h0004_0001);
    rd(32'h10, r);
    check("irq pop", r, 32'hA0);
    wr(32'h08, 32'h1, 4'h1);
    @(negedge clk);
    check("irq cleared", {31'h0, irq}, 32'h0);
    rd(32'h08, r);
    check("irq status clr", r, 32'h0003_0000);
    for (int i = 1; i < 4; i++) rd(32'h10, r);
    wr(32'h04, 32'h0, 4'hF);

    // Timestamp load: read sampled 10 edges after the write edge
    wr(32'h14, 32'h0, 4'h1);
    repeat (9) @(negedge clk);
    rd(32'h14, r);
    total++;
    if (r != 32'd9 && r != 32'd10) begin
      bad++;
      $display("FAIL ts load: got %h expected 9 or 10", r);
    end

    // Timestamp wrap
    force dut.ts_q = 32'hFFFF_FFFF;
    rden = 1'b1; addr = 32'h14;
    #1 release dut.ts_q;
    @(negedge clk);
    rden = 1'b0;
    check("ts max", rd_data, 32'hFFFF_FFFF);
    rd(32'h14, r);
    check("ts wrap", r, 32'h0);

    // Reset mid-operation with a pending read
    wr(32'h04, 32'hFF, 4'h1);
    push(32'h55);
    push(32'h66);
    rst = 1'b1; rden = 1'b1; addr = 32'h00;
    @(negedge clk);
    rst = 1'b0; rden = 1'b0;
    check("midrst rd_data", rd_data, 32'h0);
    check("midrst ctrl_out", ctrl_out, 32'h0);
    rd(32'h08, r);
    check("midrst status", r, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
